// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-read-port register file.
package regfile_pkg;

   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero/range/busy qualification, optional write-first
// bypass (RF_WRITE_BYPASS_EN), output held while en is low.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W    = RF_DATA_W,
   parameter int ADDR_W    = RF_ADDR_W,
   parameter int DEPTH     = 1 << ADDR_W,
   parameter int ZERO_REG0 = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic              busy,
   input  logic [DATA_W-1:0] mem_rd,
   input  logic              wr_ok,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] data
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic              in_rng;
   logic [DATA_W-1:0] nxt;

   assign in_rng = {1'b0, addr} < DEPTH_C;

   always_comb begin
      nxt = '0;
      if (!busy && in_rng && !(ZERO_REG0 != 0 && addr == '0)) begin
         nxt = mem_rd;
`ifdef RF_WRITE_BYPASS_EN
         // wr_ok already excludes dropped writes, so a hit is always a legal entry
         if (wr_ok && wa == addr) nxt = wd;
`endif
      end
   end

`ifndef RF_WRITE_BYPASS_EN
   logic unused_byp;
   assign unused_byp = ^{wr_ok, wa, wd};
`endif

   always_ff @(posedge clk) begin
      if (reset)   data <= '0;
      else if (en) data <= nxt;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: one write port, registered reads, clear sweep FSM.
// Optional write-to-read bypass selected by RF_WRITE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W    = RF_DATA_W,
   parameter int ADDR_W    = RF_ADDR_W,
   parameter int DEPTH     = 1 << ADDR_W,
   parameter int NUM_RD    = RF_NUM_RD,
   parameter int ZERO_REG0 = 1
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic                     clr,
   output logic                     busy
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr, ptr_d;
   logic              wr_ok;

   logic [NUM_RD-1:0][ADDR_W-1:0] addr_a;
   logic [NUM_RD-1:0][DATA_W-1:0] data_a;

   assign busy    = (state_q == RF_CLEAR);
   assign addr_a  = rd_addr;
   assign rd_data = data_a;

   assign wr_ok = we && !busy && ({1'b0, wa} < DEPTH_C) &&
                  !(ZERO_REG0 != 0 && wa == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RF_CLEAR;
         clr_ptr <= '0;
      end else begin
         state_q <= state_d;
         clr_ptr <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = clr_ptr;
      unique case (state_q)
         RF_IDLE: if (clr) begin
            state_d = RF_CLEAR;
            ptr_d   = '0;
         end
         RF_CLEAR: begin
            // clr is ignored here; only reset restarts a running sweep
            ptr_d = clr_ptr + 1'b1;
            if (clr_ptr == LAST) state_d = RF_IDLE;
         end
         default: state_d = RF_IDLE;
      endcase
   end

   // Storage has no reset; the sweep zeroes it one entry per cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy)       mem[clr_ptr] <= '0;
         else if (wr_ok) mem[wa]      <= wd;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_rd_port #(
         .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG0(ZERO_REG0)
      ) u_port (
         .clk   (clk),
         .reset (reset),
         .en    (rd_en[i]),
         .addr  (addr_a[i]),
         .busy  (busy),
         .mem_rd(mem[addr_a[i]]),
         .wr_ok (wr_ok),
         .wa    (wa),
         .wd    (wd),
         .data  (data_a[i])
      );
   end

endmodule
